// File: rtl/calc_sequencer.sv
// calc_sequencer: operand-entry and calculation sequencer for the calculator datapath.
// The user enters NUM_OPERANDS operands with one confirm button. The sequencer then folds
// them left-to-right through the selected operation, one step per cycle, and holds the
// result until the user restarts or cancels.
module calc_sequencer #(
    parameter int WIDTH        = 8,
    parameter int NUM_OPERANDS = 2,
    parameter int IW           = (NUM_OPERANDS > 2) ? $clog2(NUM_OPERANDS) : 1,
    parameter int RW           = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             confirm,
    input  logic             cancel,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       op_in,
    output logic [2:0]       state,
    output logic [IW-1:0]    operand_idx,
    output logic [RW-1:0]    result,
    output logic             result_valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        ENTRY_WR = 3'd2,
        CALC     = 3'd3,
        DONE     = 3'd4,
        DONE_WR  = 3'd5
    } stateT;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_AND = 2'b11
    } opT;

    // Index of the final operand. The operation code is captured with it, and
    // the calculation finishes on the step that consumes it.
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OPERANDS - 1);

    stateT            stateQ;
    logic [IW-1:0]    idxQ;
    logic [IW-1:0]    stepQ;
    logic [1:0]       opcodeQ;
    logic [RW-1:0]    accQ;
    logic [RW-1:0]    resultQ;
    logic             validQ;
    logic             overflowQ;
    logic             busyQ;
    logic [WIDTH-1:0] operandQ [NUM_OPERANDS];

    logic [RW-1:0]    operandExt;
    logic [RW:0]      sumFull;
    logic [RW:0]      diffFull;
    logic [2*RW-1:0]  prodFull;
    logic [RW-1:0]    accD;
    logic             stepOvfD;

    // One fold step: combine the accumulator with the current operand, and flag any
    // unsigned overflow (carry, borrow or truncated product bits) from that step.
    always_comb begin
        operandExt = RW'(operandQ[stepQ]);
        sumFull    = {1'b0, accQ} + {1'b0, operandExt};
        diffFull   = {1'b0, accQ} - {1'b0, operandExt};
        prodFull   = {{RW{1'b0}}, accQ} * {{RW{1'b0}}, operandExt};
        accD       = accQ;
        stepOvfD   = 1'b0;
        case (opcodeQ)
            OP_ADD: begin
                accD     = sumFull[RW-1:0];
                stepOvfD = sumFull[RW];
            end
            OP_SUB: begin
                accD     = diffFull[RW-1:0];
                stepOvfD = diffFull[RW];
            end
            OP_MUL: begin
                accD     = prodFull[RW-1:0];
                stepOvfD = |prodFull[2*RW-1:RW];
            end
            default: begin
                accD     = accQ & operandExt;
                stepOvfD = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: reset, then cancel, then the per-state behaviour. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= IDLE;
            idxQ      <= '0;
            stepQ     <= '0;
            opcodeQ   <= '0;
            accQ      <= '0;
            resultQ   <= '0;
            validQ    <= 1'b0;
            overflowQ <= 1'b0;
            busyQ     <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                operandQ[i] <= '0;
            end
        end else if (cancel && (stateQ != IDLE)) begin
            // Abort back to the first operand. Captured operands and the last result stay as they are.
            stateQ    <= ENTRY;
            idxQ      <= '0;
            validQ    <= 1'b0;
            overflowQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    stateQ <= ENTRY;
                    busyQ  <= 1'b0;
                end
                ENTRY: begin
                    if (confirm) begin
                        operandQ[idxQ] <= data_in;
                        if (idxQ == LAST_IDX) begin
                            opcodeQ <= op_in;
                        end
                        stateQ <= ENTRY_WR;
                    end
                end
                ENTRY_WR: begin
                    // Wait for the button release so that a long press captures only once.
                    if (!confirm) begin
                        if (idxQ != LAST_IDX) begin
                            idxQ   <= idxQ + IW'(1);
                            stateQ <= ENTRY;
                        end else begin
                            accQ      <= RW'(operandQ[0]);
                            stepQ     <= IW'(1);
                            overflowQ <= 1'b0;
                            busyQ     <= 1'b1;
                            stateQ    <= CALC;
                        end
                    end
                end
                CALC: begin
                    accQ      <= accD;
                    overflowQ <= overflowQ | stepOvfD;
                    stepQ     <= stepQ + IW'(1);
                    if (stepQ == LAST_IDX) begin
                        resultQ <= accD;
                        validQ  <= 1'b1;
                        busyQ   <= 1'b0;
                        stateQ  <= DONE;
                    end
                end
                DONE: begin
                    if (confirm) begin
                        stateQ <= DONE_WR;
                    end
                end
                DONE_WR: begin
                    if (!confirm) begin
                        idxQ      <= '0;
                        validQ    <= 1'b0;
                        overflowQ <= 1'b0;
                        stateQ    <= ENTRY;
                    end
                end
                default: begin
                    // Codes 6 and 7 are unreachable. They recover to IDLE.
                    stateQ <= IDLE;
                    busyQ  <= 1'b0;
                end
            endcase
        end
    end

    assign state        = stateQ;
    assign operand_idx  = idxQ;
    assign result       = resultQ;
    assign result_valid = validQ;
    assign overflow     = overflowQ;
    assign busy         = busyQ;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: testbench for calc_sequencer. It drives three instances
// (NUM_OPERANDS = 2, 3 and 4) with table vectors, hand-written corner cases and
// random calculations checked against an arithmetic reference model.
module tb_calc_sequencer;

   typedef struct packed {
      logic [1:0]      unit;
      logic [3:0][7:0] v;
      logic [1:0]      op;
      logic [15:0]     expRes;
      logic            expOvf;
   } vecT;

   logic clk;
   logic reset;
   logic        confirmV [3];
   logic        cancelV  [3];
   logic [7:0]  dataV    [3];
   logic [1:0]  opV      [3];
   logic [2:0]  stateV   [3];
   logic [15:0] resultV  [3];
   logic        validV   [3];
   logic        ovfV     [3];
   logic        busyV    [3];
   logic        idx0;
   logic [1:0]  idx1;
   logic [1:0]  idx2;

   int nChecks = 0;
   int nFails  = 0;
   logic [15:0] lastRes [3];
   vecT tbl [12];

   calc_sequencer #(.WIDTH(8), .NUM_OPERANDS(2)) dut2 (
      .clk(clk), .reset(reset), .confirm(confirmV[0]), .cancel(cancelV[0]),
      .data_in(dataV[0]), .op_in(opV[0]), .state(stateV[0]), .operand_idx(idx0),
      .result(resultV[0]), .result_valid(validV[0]), .overflow(ovfV[0]), .busy(busyV[0]));

   calc_sequencer #(.WIDTH(8), .NUM_OPERANDS(3)) dut3 (
      .clk(clk), .reset(reset), .confirm(confirmV[1]), .cancel(cancelV[1]),
      .data_in(dataV[1]), .op_in(opV[1]), .state(stateV[1]), .operand_idx(idx1),
      .result(resultV[1]), .result_valid(validV[1]), .overflow(ovfV[1]), .busy(busyV[1]));

   calc_sequencer #(.WIDTH(8), .NUM_OPERANDS(4)) dut4 (
      .clk(clk), .reset(reset), .confirm(confirmV[2]), .cancel(cancelV[2]),
      .data_in(dataV[2]), .op_in(opV[2]), .state(stateV[2]), .operand_idx(idx2),
      .result(resultV[2]), .result_valid(validV[2]), .overflow(ovfV[2]), .busy(busyV[2]));

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so that a stuck run still ends with a report.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] idxOf(input int u);
      case (u)
         0:       return {31'b0, idx0};
         1:       return {30'b0, idx1};
         default: return {30'b0, idx2};
      endcase
   endfunction

   function automatic vecT mkVec(input int u, input int a, input int b, input int c,
                                 input int d, input int op, input int res, input int ovf);
      vecT t;
      t.unit   = 2'(u);
      t.v[0]   = 8'(a);
      t.v[1]   = 8'(b);
      t.v[2]   = 8'(c);
      t.v[3]   = 8'(d);
      t.op     = 2'(op);
      t.expRes = 16'(res);
      t.expOvf = ovf[0];
      return t;
   endfunction

   // Reference fold using plain integer arithmetic on a 16-bit unsigned result.
   function automatic void model(input int n, input logic [3:0][7:0] v, input logic [1:0] op,
                                 output logic [15:0] r, output logic o);
      longint acc;
      longint x;
      acc = longint'(v[0]);
      o   = 1'b0;
      for (int i = 1; i < n; i++) begin
         x = longint'(v[i]);
         case (op)
            2'd0: begin
               acc = acc + x;
               if (acc > 65535) begin o = 1'b1; acc = acc - 65536; end
            end
            2'd1: begin
               if (x > acc) begin o = 1'b1; acc = acc + 65536 - x; end
               else acc = acc - x;
            end
            2'd2: begin
               acc = acc * x;
               if (acc > 65535) o = 1'b1;
               acc = acc % 65536;
            end
            default: acc = acc & x;
         endcase
      end
      r = acc[15:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one unit's inputs, then advance to the next falling edge.
   task automatic applyStimulus(input int u, input logic conf, input logic canc,
                                input logic [7:0] data, input logic [1:0] op);
      confirmV[u] = conf;
      cancelV[u]  = canc;
      dataV[u]    = data;
      opV[u]      = op;
      @(negedge clk);
   endtask

   // Enter all operands with clean press/release. The real op is presented only with the last operand.
   task automatic enterOps(input int u, input logic [3:0][7:0] v, input logic [1:0] op);
      int n;
      logic [1:0] opSel;
      n = u + 2;
      checkOutput($sformatf("u%0d entry start state", u), 32'(stateV[u]), 32'd1);
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("u%0d operand_idx %0d", u, i), idxOf(u), 32'(i));
         opSel = (i == n - 1) ? op : 2'($urandom_range(0, 3));
         applyStimulus(u, 1'b1, 1'b0, v[i], opSel);
         checkOutput($sformatf("u%0d press state", u), 32'(stateV[u]), 32'd2);
         applyStimulus(u, 1'b0, 1'b0, v[i], opSel);
      end
   endtask

   task automatic runCalc(input int u, input logic [3:0][7:0] v, input logic [1:0] op,
                          input logic [15:0] expRes, input logic expOvf, input bit restart);
      int n;
      int k;
      int busyCnt;
      n = u + 2;
      enterOps(u, v, op);
      opV[u]  = 2'($urandom_range(0, 3));
      k       = 0;
      busyCnt = 0;
      while (validV[u] !== 1'b1 && k < 20) begin
         if (busyV[u] === 1'b1) busyCnt++;
         @(negedge clk);
         k++;
      end
      checkOutput($sformatf("u%0d result_valid", u), 32'(validV[u]), 32'd1);
      checkOutput($sformatf("u%0d latency", u), 32'(k), 32'(n - 1));
      checkOutput($sformatf("u%0d busy cycles", u), 32'(busyCnt), 32'(n - 1));
      checkOutput($sformatf("u%0d result", u), 32'(resultV[u]), 32'(expRes));
      checkOutput($sformatf("u%0d overflow", u), 32'(ovfV[u]), 32'(expOvf));
      checkOutput($sformatf("u%0d DONE state", u), 32'(stateV[u]), 32'd4);
      checkOutput($sformatf("u%0d busy in DONE", u), 32'(busyV[u]), 32'd0);
      lastRes[u] = expRes;
      if (restart) begin
         applyStimulus(u, 1'b1, 1'b0, 8'd0, 2'd0);
         checkOutput($sformatf("u%0d DONE_WR state", u), 32'(stateV[u]), 32'd5);
         checkOutput($sformatf("u%0d valid in DONE_WR", u), 32'(validV[u]), 32'd1);
         applyStimulus(u, 1'b0, 1'b0, 8'd0, 2'd0);
         checkOutput($sformatf("u%0d restart state", u), 32'(stateV[u]), 32'd1);
         checkOutput($sformatf("u%0d restart idx", u), idxOf(u), 32'd0);
         checkOutput($sformatf("u%0d restart valid", u), 32'(validV[u]), 32'd0);
         checkOutput($sformatf("u%0d restart overflow", u), 32'(ovfV[u]), 32'd0);
         checkOutput($sformatf("u%0d restart result kept", u), 32'(resultV[u]), 32'(expRes));
      end
   endtask

   task automatic checkResetValues(input int u);
      checkOutput($sformatf("u%0d reset state", u), 32'(stateV[u]), 32'd0);
      checkOutput($sformatf("u%0d reset idx", u), idxOf(u), 32'd0);
      checkOutput($sformatf("u%0d reset result", u), 32'(resultV[u]), 32'd0);
      checkOutput($sformatf("u%0d reset valid", u), 32'(validV[u]), 32'd0);
      checkOutput($sformatf("u%0d reset overflow", u), 32'(ovfV[u]), 32'd0);
      checkOutput($sformatf("u%0d reset busy", u), 32'(busyV[u]), 32'd0);
   endtask

   // Main sequence: reset, table vectors, hand-written corner cases, then random calculations.
   initial begin
      logic [3:0][7:0] rv;
      logic [1:0]      rop;
      logic [15:0]     mRes;
      logic            mOvf;
      int              ru;

      tbl[0]  = mkVec(0, 25, 17, 0, 0, 0, 42, 0);
      tbl[1]  = mkVec(0, 5, 9, 0, 0, 1, 16'hFFFC, 1);
      tbl[2]  = mkVec(1, 200, 200, 2, 0, 2, 16'h3880, 1);
      tbl[3]  = mkVec(0, 8'hF0, 8'h3C, 0, 0, 3, 16'h0030, 0);
      tbl[4]  = mkVec(2, 255, 255, 255, 255, 0, 1020, 0);
      tbl[5]  = mkVec(2, 255, 255, 255, 255, 2, 16'hFC01, 1);
      tbl[6]  = mkVec(1, 10, 3, 2, 0, 1, 5, 0);
      tbl[7]  = mkVec(0, 0, 1, 0, 0, 1, 16'hFFFF, 1);
      tbl[8]  = mkVec(0, 0, 0, 0, 0, 1, 0, 0);
      tbl[9]  = mkVec(1, 200, 200, 1, 0, 2, 16'h9C40, 0);
      tbl[10] = mkVec(2, 8'hFF, 8'h0F, 8'hF3, 8'h33, 3, 3, 0);
      tbl[11] = mkVec(1, 1, 2, 3, 0, 1, 16'hFFFC, 1);

      for (int u = 0; u < 3; u++) begin
         confirmV[u] = 1'b0;
         cancelV[u]  = 1'b0;
         dataV[u]    = 8'd0;
         opV[u]      = 2'd0;
         lastRes[u]  = 16'd0;
      end
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int u = 0; u < 3; u++) checkResetValues(u);
      reset = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 3; u++)
         checkOutput($sformatf("u%0d IDLE to ENTRY", u), 32'(stateV[u]), 32'd1);

      $display("[TB] table vectors");
      for (int t = 0; t < 12; t++)
         runCalc(int'(tbl[t].unit), tbl[t].v, tbl[t].op, tbl[t].expRes, tbl[t].expOvf, 1'b1);

      $display("[TB] long press and late op change");
      applyStimulus(0, 1'b1, 1'b0, 8'd3, 2'd0);
      for (int i = 0; i < 19; i++) applyStimulus(0, 1'b1, 1'b0, 8'd7, 2'd0);
      checkOutput("long press holds ENTRY_WR", 32'(stateV[0]), 32'd2);
      applyStimulus(0, 1'b0, 1'b0, 8'd7, 2'd0);
      checkOutput("long press idx", idxOf(0), 32'd1);
      applyStimulus(0, 1'b1, 1'b0, 8'd4, 2'd0);
      applyStimulus(0, 1'b0, 1'b0, 8'd4, 2'd0);
      checkOutput("long press CALC state", 32'(stateV[0]), 32'd3);
      applyStimulus(0, 1'b0, 1'b0, 8'd4, 2'd2);
      checkOutput("long press result", 32'(resultV[0]), 32'd7);
      checkOutput("long press valid", 32'(validV[0]), 32'd1);
      checkOutput("long press overflow", 32'(ovfV[0]), 32'd0);
      applyStimulus(0, 1'b1, 1'b0, 8'd0, 2'd0);
      applyStimulus(0, 1'b0, 1'b0, 8'd0, 2'd0);
      checkOutput("long press restart", 32'(stateV[0]), 32'd1);
      lastRes[0] = 16'd7;

      $display("[TB] cancel cases");
      applyStimulus(0, 1'b1, 1'b0, 8'd11, 2'd0);
      applyStimulus(0, 1'b0, 1'b0, 8'd11, 2'd0);
      checkOutput("pre-cancel idx", idxOf(0), 32'd1);
      applyStimulus(0, 1'b0, 1'b1, 8'd11, 2'd0);
      checkOutput("cancel entry state", 32'(stateV[0]), 32'd1);
      checkOutput("cancel entry idx", idxOf(0), 32'd0);
      applyStimulus(0, 1'b1, 1'b1, 8'd99, 2'd0);
      checkOutput("cancel beats confirm state", 32'(stateV[0]), 32'd1);
      checkOutput("cancel beats confirm idx", idxOf(0), 32'd0);
      applyStimulus(0, 1'b0, 1'b0, 8'd0, 2'd0);
      runCalc(0, {8'd0, 8'd0, 8'd9, 8'd5}, 2'd1, 16'hFFFC, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 8'd0, 2'd0);
      checkOutput("cancel DONE state", 32'(stateV[0]), 32'd1);
      checkOutput("cancel DONE valid", 32'(validV[0]), 32'd0);
      checkOutput("cancel DONE overflow", 32'(ovfV[0]), 32'd0);
      checkOutput("cancel DONE result kept", 32'(resultV[0]), 32'hFFFC);
      applyStimulus(0, 1'b0, 1'b0, 8'd0, 2'd0);

      enterOps(1, {8'd0, 8'd3, 8'd2, 8'd1}, 2'd0);
      checkOutput("u1 CALC state", 32'(stateV[1]), 32'd3);
      applyStimulus(1, 1'b0, 1'b1, 8'd0, 2'd0);
      checkOutput("cancel CALC state", 32'(stateV[1]), 32'd1);
      checkOutput("cancel CALC valid", 32'(validV[1]), 32'd0);
      checkOutput("cancel CALC busy", 32'(busyV[1]), 32'd0);
      checkOutput("cancel CALC result kept", 32'(resultV[1]), 32'(lastRes[1]));
      applyStimulus(1, 1'b0, 1'b0, 8'd0, 2'd0);

      $display("[TB] reset during CALC");
      enterOps(2, {8'd4, 8'd3, 8'd2, 8'd1}, 2'd0);
      checkOutput("u2 CALC cycle 1", 32'(stateV[2]), 32'd3);
      @(negedge clk);
      checkOutput("u2 CALC cycle 2", 32'(stateV[2]), 32'd3);
      reset = 1'b1;
      @(negedge clk);
      checkResetValues(2);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("u2 post-reset ENTRY", 32'(stateV[2]), 32'd1);
      for (int u = 0; u < 3; u++) lastRes[u] = 16'd0;

      $display("[TB] random calculations");
      for (int it = 0; it < 30; it++) begin
         ru = int'($urandom_range(0, 2));
         for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 5))
               0:       rv[i] = 8'd0;
               1:       rv[i] = 8'd255;
               default: rv[i] = 8'($urandom_range(0, 255));
            endcase
         end
         rop = 2'($urandom_range(0, 3));
         model(ru + 2, rv, rop, mRes, mOvf);
         runCalc(ru, rv, rop, mRes, mOvf, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
